// File: rtl/f5_selftest_ctrl_pkg.sv
// Shared definitions for the f5 gate self-test sequencer: state encodings,
// the reference truth table of s = a'.b and datapath widths.
package f5_selftest_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_APPLY = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } f5_state_e;

  // Bit m is the expected gate output for {a,b} = m.
  localparam logic [3:0]  F5_TT   = 4'b0010;
  localparam int unsigned F5_NMIN = 4;
  localparam int unsigned F5_MW   = 2;
  localparam int unsigned F5_CW   = 4;

endpackage

// File: rtl/f5_settle_timer.sv
// Loadable down-counter that times the settle window between driving the
// gate inputs and sampling the gate outputs; parks at zero once expired.
module f5_settle_timer
  import f5_selftest_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [F5_CW-1:0] value,
  output logic             zero
);

  localparam logic [F5_CW-1:0] CNT_ONE = 1;

  logic [F5_CW-1:0] cnt_q;
  logic [F5_CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/f5_selftest_ctrl.sv
// Self-test sequencer for the 2-input f5 gate: steps minterms 0..3 onto x/y,
// waits SETTLE_CYC cycles, checks both implementations against EXP_TT.
module f5_selftest_ctrl
  import f5_selftest_ctrl_pkg::*;
#(
  parameter int unsigned          SETTLE_CYC = 2,
  parameter logic [F5_NMIN-1:0]   EXP_TT     = F5_TT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               x_o,
  output logic               y_o,
  input  logic               sa_i,
  input  logic               sb_i,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [F5_NMIN-1:0] err_mask,
  output logic [F5_MW-1:0]   cur_m
);

  localparam logic [F5_CW-1:0] SETTLE_LD = F5_CW'(SETTLE_CYC - 1);
  localparam logic [F5_MW-1:0] LAST_M    = F5_MW'(F5_NMIN - 1);
  localparam logic [F5_MW-1:0] M_STEP    = 1;

  f5_state_e          state_q, state_d;
  logic               x_q, x_d;
  logic               y_q, y_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [F5_NMIN-1:0] err_mask_q, err_mask_d;
  logic [F5_MW-1:0]   cur_m_q, cur_m_d;
  logic               tmr_load;
  logic               tmr_zero;

  f5_settle_timer u_settle_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (tmr_load),
    .value (SETTLE_LD),
    .zero  (tmr_zero)
  );

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    err_mask_d = err_mask_q;
    cur_m_d    = cur_m_q;
    tmr_load   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          err_mask_d = '0;
          pass_d     = 1'b0;
          cur_m_d    = '0;
          busy_d     = 1'b1;
          state_d    = S_APPLY;
        end
      end
      S_APPLY: begin
        {x_d, y_d} = cur_m_q;
        tmr_load   = 1'b1;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (tmr_zero) begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        err_mask_d[cur_m_q] = (sa_i != EXP_TT[cur_m_q]) | (sb_i != EXP_TT[cur_m_q]);
        if (cur_m_q == LAST_M) begin
          state_d = S_DONE;
        end else begin
          cur_m_d = cur_m_q + M_STEP;
          state_d = S_APPLY;
        end
      end
      S_DONE: begin
        // err_mask_q already holds the last minterm's result written in CHECK.
        done_d  = 1'b1;
        busy_d  = 1'b0;
        pass_d  = ~|err_mask_q;
        x_d     = 1'b0;
        y_d     = 1'b0;
        cur_m_d = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      x_q        <= 1'b0;
      y_q        <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_mask_q <= '0;
      cur_m_q    <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_mask_q <= err_mask_d;
      cur_m_q    <= cur_m_d;
    end
  end

  assign x_o      = x_q;
  assign y_o      = y_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign err_mask = err_mask_q;
  assign cur_m    = cur_m_q;

endmodule

// File: tb/tb_f5_selftest_ctrl.sv
// Bench for f5_selftest_ctrl: three instances (SETTLE_CYC 2, 1, 15) driven by
// a behavioural f5 gate model with selectable faults.
module tb_f5_selftest_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_r [3];
  logic       x_v     [3];
  logic       y_v     [3];
  logic       sa_v    [3];
  logic       sb_v    [3];
  logic       busy_v  [3];
  logic       done_v  [3];
  logic       pass_v  [3];
  logic [3:0] mask_v  [3];
  logic [1:0] curm_v  [3];

  int fault;
  int phase;
  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  // Gate model: 0 good, 1 sa stuck-0, 2 sb inverted, 3 sa stuck-1,
  // 4 sb follows a, 5 sa = a|b, 6 sa wrong everywhere except the CHECK cycle (period 4).
  function automatic logic model_sa(input int mode, input int ph, input logic a, input logic b);
    logic g;
    g = ~a & b;
    case (mode)
      1:       return 1'b0;
      3:       return 1'b1;
      5:       return a | b;
      6:       return g ^ ((ph % 4) != 3);
      default: return g;
    endcase
  endfunction

  function automatic logic model_sb(input int mode, input logic a, input logic b);
    logic g;
    g = ~a & b;
    case (mode)
      2:       return ~g;
      4:       return a;
      default: return g;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_model
    assign sa_v[g] = model_sa(fault, phase, x_v[g], y_v[g]);
    assign sb_v[g] = model_sb(fault, x_v[g], y_v[g]);
  end

  f5_selftest_ctrl #(.SETTLE_CYC(2), .EXP_TT(4'b0010)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start_r[0]), .x_o(x_v[0]), .y_o(y_v[0]),
    .sa_i(sa_v[0]), .sb_i(sb_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .pass(pass_v[0]), .err_mask(mask_v[0]), .cur_m(curm_v[0])
  );

  f5_selftest_ctrl #(.SETTLE_CYC(1), .EXP_TT(4'b0010)) u_dut_s1 (
    .clk(clk), .rst_n(rst_n), .start(start_r[1]), .x_o(x_v[1]), .y_o(y_v[1]),
    .sa_i(sa_v[1]), .sb_i(sb_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .pass(pass_v[1]), .err_mask(mask_v[1]), .cur_m(curm_v[1])
  );

  f5_selftest_ctrl #(.SETTLE_CYC(15), .EXP_TT(4'b0010)) u_dut_s15 (
    .clk(clk), .rst_n(rst_n), .start(start_r[2]), .x_o(x_v[2]), .y_o(y_v[2]),
    .sa_i(sa_v[2]), .sb_i(sb_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .pass(pass_v[2]), .err_mask(mask_v[2]), .cur_m(curm_v[2])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    phase = phase + 1;
  endtask

  function automatic logic [10:0] all_outs(input int d);
    return {x_v[d], y_v[d], busy_v[d], done_v[d], pass_v[d], mask_v[d], curm_v[d]};
  endfunction

  // Starts a run on instance d (period p = SETTLE_CYC+2), returns cycles from
  // the accepting edge to done, the x/y pair seen in each CHECK cycle, and the
  // number of cycles busy was low before done.
  task automatic run_dut(input int d, input int p, input int repulse_c, input bit hold,
                         output int lat, output logic [7:0] seq, output int busy_bad);
    start_r[d] = 1'b1;
    @(posedge clk);
    #1;
    phase    = 0;
    lat      = -1;
    seq      = '0;
    busy_bad = 0;
    for (int c = 0; c <= 4 * p + 40; c++) begin
      if (c > 0) tick();
      if (!hold) start_r[d] = (c == repulse_c);
      if (done_v[d]) begin
        lat = c;
        break;
      end
      if (!busy_v[d]) busy_bad++;
      if (c < 4 * p && (c % p) == p - 1) seq[2 * (c / p) +: 2] = {x_v[d], y_v[d]};
    end
  endtask

  typedef struct {
    int         d;
    int         mode;
    logic [3:0] mask;
    logic       pass;
    int         lat;
  } vec_t;

  vec_t vecs [11];
  int   per  [3];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int         lat;
    int         bb;
    logic [7:0] seq;

    per  = '{4, 3, 17};
    vecs = '{
      '{0, 0, 4'b0000, 1'b1, 17},
      '{0, 1, 4'b0010, 1'b0, 17},
      '{0, 2, 4'b1111, 1'b0, 17},
      '{0, 3, 4'b1101, 1'b0, 17},
      '{0, 4, 4'b1110, 1'b0, 17},
      '{0, 5, 4'b1100, 1'b0, 17},
      '{0, 6, 4'b0000, 1'b1, 17},
      '{1, 0, 4'b0000, 1'b1, 13},
      '{1, 1, 4'b0010, 1'b0, 13},
      '{2, 0, 4'b0000, 1'b1, 69},
      '{2, 2, 4'b1111, 1'b0, 69}
    };

    rst_n = 1'b0;
    fault = 0;
    phase = 0;
    for (int i = 0; i < 3; i++) start_r[i] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) check($sformatf("reset outs d%0d", i), 32'(all_outs(i)), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int unsigned i = 0; i < 11; i++) begin
      fault = vecs[i].mode;
      run_dut(vecs[i].d, per[vecs[i].d], -1, 1'b0, lat, seq, bb);
      check($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d err_mask", i), 32'(mask_v[vecs[i].d]), 32'(vecs[i].mask));
      check($sformatf("v%0d pass", i), 32'(pass_v[vecs[i].d]), 32'(vecs[i].pass));
      check($sformatf("v%0d busy at done", i), 32'(busy_v[vecs[i].d]), 32'd0);
      check($sformatf("v%0d xy/cur_m at done", i),
            32'({x_v[vecs[i].d], y_v[vecs[i].d], curm_v[vecs[i].d]}), 32'd0);
      check($sformatf("v%0d xy sequence", i), 32'(seq), 32'h00e4);
      check($sformatf("v%0d busy drop in run", i), 32'(bb), 32'd0);
      tick();
      check($sformatf("v%0d done pulse width", i), 32'(done_v[vecs[i].d]), 32'd0);
    end

    // Results persist while idle.
    fault = 1;
    run_dut(0, 4, -1, 1'b0, lat, seq, bb);
    fault = 2;
    repeat (5) tick();
    check("persist err_mask", 32'(mask_v[0]), 32'h2);
    check("persist pass", 32'(pass_v[0]), 32'd0);

    // start re-pulsed mid-run is ignored.
    fault = 0;
    run_dut(0, 4, 5, 1'b0, lat, seq, bb);
    check("repulse latency", 32'(lat), 32'd17);
    check("repulse pass", 32'(pass_v[0]), 32'd1);
    check("repulse busy drop", 32'(bb), 32'd0);
    tick();
    check("repulse no restart", 32'(busy_v[0]), 32'd0);

    // start held high: back-to-back runs, pass cleared on acceptance.
    run_dut(0, 4, -1, 1'b1, lat, seq, bb);
    check("hold run1 latency", 32'(lat), 32'd17);
    check("hold run1 pass", 32'(pass_v[0]), 32'd1);
    tick();
    start_r[0] = 1'b0;
    fault      = 1;
    check("hold run2 busy", 32'(busy_v[0]), 32'd1);
    check("hold run2 pass cleared", 32'(pass_v[0]), 32'd0);
    lat = -1;
    for (int c = 0; c <= 60; c++) begin
      if (c > 0) tick();
      if (done_v[0]) begin
        lat = c;
        break;
      end
    end
    check("hold run2 latency", 32'(lat), 32'd17);
    check("hold run2 err_mask", 32'(mask_v[0]), 32'h2);
    check("hold run2 pass", 32'(pass_v[0]), 32'd0);
    tick();

    // Asynchronous reset mid-WAIT at minterm 2, then a clean run.
    fault      = 2;
    start_r[0] = 1'b1;
    tick();
    start_r[0] = 1'b0;
    repeat (9) tick();
    check("pre-reset cur_m", 32'(curm_v[0]), 32'd2);
    check("pre-reset err_mask", 32'(mask_v[0]), 32'h3);
    check("pre-reset xy", 32'({x_v[0], y_v[0]}), 32'h2);
    rst_n = 1'b0;
    #1;
    check("async reset outs", 32'(all_outs(0)), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    fault = 0;
    run_dut(0, 4, -1, 1'b0, lat, seq, bb);
    check("post-reset latency", 32'(lat), 32'd17);
    check("post-reset pass", 32'(pass_v[0]), 32'd1);
    check("post-reset err_mask", 32'(mask_v[0]), 32'h0);
    check("post-reset xy sequence", 32'(seq), 32'h00e4);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
